// File: rtl/tensorflowe_seq.sv
// -----------------------------------------------------------------------------
// tensorflowe_seq
//   Command-driven sequencer in front of the TensorFlowE core. One command at a
//   time: optionally clear the core accumulator, stream cmd_len operand bytes
//   into it (write+accumulate strobes), pulse the read strobe, wait for the
//   core's result and hand it back on a valid/ready port.
//
//   Optional feature macro: TFE_SEQ_TIMEOUT_EN
//     defined   -> watchdog in WAIT; after TIMEOUT_CYC cycles without
//                  core_result_valid the result is 'hFF and err is raised
//                  (sticky until the next command is accepted).
//     undefined -> WAIT waits forever, err is constant 0.
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready         command handshake, cmd_len/cmd_clear payload
//   src_valid/src_ready         operand byte stream, src_data payload
//   res_valid/res_ready         result handshake, res_data payload
//   core_data/core_write/
//   core_accu/core_clear/
//   core_read                   strobes and data towards the core
//   core_result/core_result_valid  result from the core
//   busy                        high whenever the sequencer is not idle
//   err                         sticky timeout flag
//
// Every output is a flop; ready/valid outputs are computed from the next state
// so that they line up with the state they belong to without any
// combinational path from inputs.
// -----------------------------------------------------------------------------
module tensorflowe_seq #(
    parameter int DATA_W      = 8,
    parameter int LEN_W       = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              cmd_clear,
    input  logic [DATA_W-1:0] src_data,
    input  logic              src_valid,
    output logic              src_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] core_data,
    output logic              core_write,
    output logic              core_accu,
    output logic              core_clear,
    output logic              core_read,
    input  logic [DATA_W-1:0] core_result,
    input  logic              core_result_valid,
    output logic              busy,
    output logic              err
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LOAD  = 3'd2,
        ST_READ  = 3'd3,
        ST_WAIT  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic [LEN_W-1:0]    rem_r;
    logic                cmd_ready_r;
    logic                src_ready_r;
    logic                res_valid_r;
    logic [DATA_W-1:0]   res_data_r;
    logic [DATA_W-1:0]   core_data_r;
    logic                core_write_r;
    logic                core_accu_r;
    logic                core_clear_r;
    logic                core_read_r;
    logic                busy_r;
    logic                accept_s;
    logic                beat_s;
    logic                tmo_hit_s;

    // Handshakes qualified by the registered ready flags actually presented
    assign accept_s = (state_r == ST_IDLE) && cmd_valid && cmd_ready_r;
    assign beat_s   = (state_r == ST_LOAD) && src_valid && src_ready_r;

`ifdef TFE_SEQ_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_cnt_r;
    logic             err_r;

    // Counts WAIT cycles; index TIMEOUT_CYC-1 is the last cycle allowed
    assign tmo_hit_s = (state_r == ST_WAIT) && !core_result_valid &&
                       (tmo_cnt_r == TMO_W'(TIMEOUT_CYC - 1));

    // Watchdog counter, restarted every time WAIT is not the current state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else if (state_r == ST_WAIT) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1'b1);
        end else begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end
    end

    // Sticky error: set on timeout, cleared by the next accepted command
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if (accept_s) begin
            err_r <= 1'b0;
        end else if (tmo_hit_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign err = err_r;
`else
    assign tmo_hit_s = 1'b0;
    assign err       = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (cmd_clear) begin
                        state_next_s = ST_CLEAR;
                    end else if (cmd_len != {LEN_W{1'b0}}) begin
                        state_next_s = ST_LOAD;
                    end else begin
                        state_next_s = ST_READ;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (rem_r != {LEN_W{1'b0}}) begin
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = ST_READ;
                end
            end
            ST_LOAD: begin
                if (beat_s && (rem_r == LEN_W'(1'b1))) begin
                    state_next_s = ST_READ;
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_READ: begin
                state_next_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (core_result_valid || tmo_hit_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                if (res_valid_r && res_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register, remaining-beat counter and every registered output.
    // Strobes are generated one cycle after the event that causes them, so
    // clear, the write pulses and the read pulse can never overlap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            rem_r        <= {LEN_W{1'b0}};
            cmd_ready_r  <= 1'b0;
            src_ready_r  <= 1'b0;
            res_valid_r  <= 1'b0;
            res_data_r   <= {DATA_W{1'b0}};
            core_data_r  <= {DATA_W{1'b0}};
            core_write_r <= 1'b0;
            core_accu_r  <= 1'b0;
            core_clear_r <= 1'b0;
            core_read_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            cmd_ready_r  <= (state_next_s == ST_IDLE);
            src_ready_r  <= (state_next_s == ST_LOAD);
            busy_r       <= (state_next_s != ST_IDLE);
            core_write_r <= beat_s;
            core_accu_r  <= beat_s;
            core_clear_r <= (state_r == ST_CLEAR);
            core_read_r  <= (state_r == ST_READ);

            if (accept_s) begin
                rem_r <= cmd_len;
            end else if (beat_s) begin
                rem_r <= rem_r - LEN_W'(1'b1);
            end else begin
                rem_r <= rem_r;
            end

            // core_data only moves on an accepted beat; gaps keep the old byte
            if (beat_s) begin
                core_data_r <= src_data;
            end else begin
                core_data_r <= core_data_r;
            end

            if ((state_r == ST_WAIT) && core_result_valid) begin
                res_data_r  <= core_result;
                res_valid_r <= 1'b1;
            end else if (tmo_hit_s) begin
                res_data_r  <= {DATA_W{1'b1}};
                res_valid_r <= 1'b1;
            end else if ((state_r == ST_DONE) && res_valid_r && res_ready) begin
                res_data_r  <= res_data_r;
                res_valid_r <= 1'b0;
            end else begin
                res_data_r  <= res_data_r;
                res_valid_r <= res_valid_r;
            end
        end
    end

    assign cmd_ready  = cmd_ready_r;
    assign src_ready  = src_ready_r;
    assign res_valid  = res_valid_r;
    assign res_data   = res_data_r;
    assign core_data  = core_data_r;
    assign core_write = core_write_r;
    assign core_accu  = core_accu_r;
    assign core_clear = core_clear_r;
    assign core_read  = core_read_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_tensorflowe_seq.sv
// -----------------------------------------------------------------------------
// tb_tensorflowe_seq
//   Bench for tensorflowe_seq. A behavioural accumulator core answers read
//   strobes after a random latency; expected results are the running byte sum
//   kept from the stimulus itself. Timeout checks are active when the design is
//   built with TFE_SEQ_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_tensorflowe_seq;

    localparam int DW  = 8;
    localparam int LW  = 4;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [LW-1:0] cmd_len = '0;
    logic          cmd_clear = 1'b0;
    logic [DW-1:0] src_data = '0;
    logic          src_valid = 1'b0;
    logic          src_ready;
    logic [DW-1:0] res_data;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [DW-1:0] core_data;
    logic          core_write;
    logic          core_accu;
    logic          core_clear;
    logic          core_read;
    logic [DW-1:0] core_result = '0;
    logic          core_result_valid = 1'b0;
    logic          busy;
    logic          err;

    tensorflowe_seq #(.DATA_W(DW), .LEN_W(LW), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len), .cmd_clear(cmd_clear),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .core_data(core_data), .core_write(core_write), .core_accu(core_accu),
        .core_clear(core_clear), .core_read(core_read),
        .core_result(core_result), .core_result_valid(core_result_valid),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Behavioural core: accumulator answering a read after 1..3 cycles
    logic [DW-1:0] core_acc = 8'h00;
    int            pend = 0;
    bit            core_mute = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            pend = 0;
            core_result_valid = 1'b0;
        end else begin
            core_result_valid = 1'b0;
            core_result = 8'($urandom);
            if (core_clear) core_acc = 8'h00;
            if (core_write && core_accu) core_acc = core_acc + core_data;
            if (core_read && !core_mute) begin
                pend = $urandom_range(1, 3);
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    core_result_valid = 1'b1;
                    core_result = core_acc;
                end
            end
        end
    end

    // Strobe monitor: pulse counts, written bytes, overlap violations, timing
    int            n_wr = 0, n_clr = 0, n_rd = 0, n_ovl = 0, cyc = 0;
    int            rd_cyc = 0, rv_cyc = 0;
    logic          rv_prev = 1'b0;
    logic [DW-1:0] wr_q[$];

    always @(negedge clk) begin
        cyc++;
        if (core_write) begin
            n_wr++;
            wr_q.push_back(core_data);
        end
        if (core_clear) n_clr++;
        if (core_read) begin
            n_rd++;
            rd_cyc = cyc;
        end
        if (core_accu !== core_write) n_ovl++;
        if (int'(core_write) + int'(core_clear) + int'(core_read) > 1) n_ovl++;
        if (res_valid && !rv_prev) rv_cyc = cyc;
        rv_prev = res_valid;
    end

    logic [DW-1:0] exp_acc = 8'h00;

    // One full command: issue, stream, collect, then audit the strobes
    task automatic run_cmd(input int len, input bit clr, input bit gaps, input int hold,
                           input bit tmo, input bit fixed);
        logic [DW-1:0] bytes[$];
        logic [DW-1:0] held;
        int b_wr, b_clr, b_rd, b_ovl, guard, i;
        b_wr = n_wr; b_clr = n_clr; b_rd = n_rd; b_ovl = n_ovl;
        if (clr) exp_acc = 8'h00;
        for (int k = 0; k < len; k++) begin
            bytes.push_back(fixed ? 8'(k + 1) : 8'($urandom));
            exp_acc = exp_acc + bytes[k];
        end

        @(negedge clk);
        guard = 0;
        while (!cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_len = LW'(len); cmd_clear = clr;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_len = LW'($urandom); cmd_clear = 1'($urandom);
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        chk("cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
        chk("err_clear_on_accept", {31'd0, err}, 32'd0);

        i = 0; guard = 0;
        while (i < len && guard < 200) begin
            if (gaps && (guard % 2 == 1)) begin
                src_valid = 1'b0; src_data = 8'($urandom);
            end else begin
                src_valid = 1'b1; src_data = bytes[i];
            end
            if (src_valid && src_ready) i++;
            @(negedge clk);
            guard++;
        end
        src_valid = 1'b0;
        chk("src_beats", i, len);

        guard = 0;
        while (!res_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("res_valid_wait", {31'd0, res_valid}, 32'd1);
        if (tmo) begin
            chk("tmo_res_data", {24'd0, res_data}, 32'hFF);
            chk("tmo_err", {31'd0, err}, 32'd1);
        end else begin
            chk("res_data", {24'd0, res_data}, {24'd0, exp_acc});
        end
        held = res_data;
        for (int h = 0; h < hold; h++) begin
            cmd_valid = 1'b1; cmd_len = LW'($urandom); cmd_clear = 1'($urandom);
            @(negedge clk);
            chk("hold_valid", {31'd0, res_valid}, 32'd1);
            chk("hold_data", {24'd0, res_data}, {24'd0, held});
            chk("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("res_valid_drop", {31'd0, res_valid}, 32'd0);
        chk("cmd_ready_back", {31'd0, cmd_ready}, 32'd1);
        chk("busy_idle", {31'd0, busy}, 32'd0);
        if (tmo) begin
            chk("tmo_latency", rv_cyc - rd_cyc, TMO);
            chk("err_sticky", {31'd0, err}, 32'd1);
        end

        chk("n_write", n_wr - b_wr, len);
        chk("n_clear", n_clr - b_clr, {31'd0, clr});
        chk("n_read", n_rd - b_rd, 1);
        chk("strobe_overlap", n_ovl - b_ovl, 0);
        for (int k = 0; k < len; k++) begin
            if (b_wr + k < wr_q.size())
                chk("wr_data", {24'd0, wr_q[b_wr + k]}, {24'd0, bytes[k]});
        end
    endtask

    initial begin
        // Power-on reset
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {23'd0, cmd_ready, src_ready, res_valid, core_write, core_accu,
                         core_clear, core_read, busy, err}, 32'd0);
        chk("rst_data", {16'd0, res_data, core_data}, 32'd0);
        rst_n = 1'b1;
        #1 chk("cmd_ready_pre_edge", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        chk("cmd_ready_post_rst", {31'd0, cmd_ready}, 32'd1);
        chk("busy_post_rst", {31'd0, busy}, 32'd0);

        // Directed: clear+3 bytes, gapped stream, held result, empty command
        run_cmd(3, 1'b1, 1'b0, 0, 1'b0, 1'b1);
        run_cmd(3, 1'b1, 1'b1, 0, 1'b0, 1'b1);
        run_cmd(4, 1'b0, 1'b0, 10, 1'b0, 1'b0);
        run_cmd(0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        run_cmd(15, 1'b0, 1'b1, 1, 1'b0, 1'b0);

        // Randomized commands
        for (int r = 0; r < 10; r++) begin
            run_cmd($urandom_range(0, 15), 1'($urandom), 1'($urandom),
                    $urandom_range(0, 3), 1'b0, 1'b0);
        end

        // Reset in the middle of LOAD (source stalls after two beats)
        @(negedge clk);
        cmd_valid = 1'b1; cmd_len = 4'd5; cmd_clear = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            src_valid = (b < 2) ? src_ready : 1'b0;
            src_data = 8'($urandom);
            @(negedge clk);
        end
        src_valid = 1'b0;
        chk("midload_busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("midrst_ctrl", {23'd0, cmd_ready, src_ready, res_valid, core_write, core_accu,
                               core_clear, core_read, busy, err}, 32'd0);
        chk("midrst_data", {16'd0, res_data, core_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("cmd_ready_after_midrst", {31'd0, cmd_ready}, 32'd1);
        chk("busy_after_midrst", {31'd0, busy}, 32'd0);
        run_cmd(2, 1'b1, 1'b0, 0, 1'b0, 1'b0);

`ifdef TFE_SEQ_TIMEOUT_EN
        // Core never answers: watchdog must fire after TMO WAIT cycles
        core_mute = 1'b1;
        run_cmd(2, 1'b0, 1'b0, 2, 1'b1, 1'b0);
        core_mute = 1'b0;
        run_cmd(1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
`else
        chk("err_tied_low", {31'd0, err}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
